// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types for the RISC-V core: scoreboard entry layout,
// post-decode stage indices and forward-select encodings.
package riscv_pipe_pkg;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  localparam int FWD_RF  = 0;

  // rd is stored at a fixed width so the struct can live in the package;
  // narrower register indices are zero-extended into it.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } sb_entry_t;

endpackage

// File: rtl/riscv_hazard_unit_if.sv
// Decode-side hazard bus: ID operand info and redirect in, pipeline
// enables, flushes, forward selects and event counters out.
interface riscv_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = $clog2(STAGES);

  logic                  id_valid_i;
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_rs1_used_i;
  logic                  id_rs2_used_i;
  logic [REG_ADDR_W-1:0] id_rd_i;
  logic                  id_reg_write_i;
  logic                  id_mem_read_i;
  logic                  redirect_i;

  logic                  pc_enable_o;
  logic                  if_id_enable_o;
  logic                  if_id_flush_o;
  logic [STAGES-1:0]     flush_o;
  logic [SEL_W-1:0]      fwd_a_sel_o;
  logic [SEL_W-1:0]      fwd_b_sel_o;
  logic                  ex_valid_o;
  logic [CNT_W-1:0]      stall_count_o;
  logic [CNT_W-1:0]      flush_count_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_reg_write_i, id_mem_read_i, redirect_i,
    input  pc_enable_o, if_id_enable_o, if_id_flush_o, flush_o,
           fwd_a_sel_o, fwd_b_sel_o, ex_valid_o, stall_count_o, flush_count_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_reg_write_i, id_mem_read_i, redirect_i,
    output pc_enable_o, if_id_enable_o, if_id_flush_o, flush_o,
           fwd_a_sel_o, fwd_b_sel_o, ex_valid_o, stall_count_o, flush_count_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination shift register (entry 0 = EX) plus per-entry
// source match vectors for the instruction currently in ID.
import riscv_pipe_pkg::*;

module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  sb_entry_t             id_entry,
  input  logic [STAGES-1:0]     flush,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic [STAGES-1:0]     match_a,
  output logic [STAGES-1:0]     match_b,
  output logic [STAGES-1:0]     is_load,
  output logic                  ex_valid
);

  sb_entry_t [STAGES-1:0] ent;

  // flush[k] kills whatever would land in entry k on this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent <= '0;
    end else begin
      ent[0] <= flush[0] ? '0 : id_entry;
      for (int k = 1; k < STAGES; k++)
        ent[k] <= flush[k] ? '0 : ent[k-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_match
      logic prod;
      assign prod       = ent[g].valid && ent[g].reg_write && (ent[g].rd != '0);
      assign match_a[g] = rs1_used && prod && (ent[g].rd == SB_RD_W'(rs1));
      assign match_b[g] = rs2_used && prod && (ent[g].rd == SB_RD_W'(rs2));
      assign is_load[g] = ent[g].mem_read;
    end
  endgenerate

  assign ex_valid = ent[0].valid;

endmodule

// File: rtl/riscv_hazard_unit.sv
// Hazard detection and forwarding control: load-use stalls, redirect
// flushes, registered EX forward selects and saturating event counters.
import riscv_pipe_pkg::*;

module riscv_hazard_unit #(
  parameter int REG_ADDR_W       = 5,
  parameter int STAGES           = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int BRANCH_STAGE     = 1,
  parameter int CNT_W            = 16
) (
  input logic               clk,
  input logic               reset,
  riscv_hazard_unit_if.slave bus
);

  localparam int SEL_W = $clog2(STAGES);

  sb_entry_t         id_entry;
  logic [STAGES-1:0] match_a, match_b, is_load, flush;
  logic              load_use, stall;
  logic [SEL_W-1:0]  sel_a_nxt, sel_b_nxt, sel_a_q, sel_b_q;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  assign id_entry = '{valid:     bus.id_valid_i,
                      rd:        SB_RD_W'(bus.id_rd_i),
                      reg_write: bus.id_reg_write_i,
                      mem_read:  bus.id_mem_read_i};

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W), .STAGES(STAGES)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .id_entry (id_entry),
    .flush    (flush),
    .rs1      (bus.id_rs1_i),
    .rs2      (bus.id_rs2_i),
    .rs1_used (bus.id_valid_i && bus.id_rs1_used_i),
    .rs2_used (bus.id_valid_i && bus.id_rs2_used_i),
    .match_a  (match_a),
    .match_b  (match_b),
    .is_load  (is_load),
    .ex_valid (bus.ex_valid_o)
  );

  // Youngest eligible producer wins, so scan oldest-to-youngest.
  always_comb begin
    load_use  = 1'b0;
    sel_a_nxt = SEL_W'(FWD_RF);
    sel_b_nxt = SEL_W'(FWD_RF);
    for (int k = STAGES-1; k >= 0; k--) begin
      if ((match_a[k] || match_b[k]) && is_load[k] && (k+1 < LOAD_READY_STAGE))
        load_use = 1'b1;
      if (k+1 <= STAGES-1) begin
        if (match_a[k]) sel_a_nxt = SEL_W'(k+1);
        if (match_b[k]) sel_b_nxt = SEL_W'(k+1);
      end
    end
  end

  // A redirect kills the consumer anyway, so it overrides the stall.
  always_comb begin
    stall = load_use && !bus.redirect_i;
    flush = '0;
    for (int k = 0; k < STAGES; k++)
      if (k <= BRANCH_STAGE) flush[k] = bus.redirect_i;
    flush[0] = flush[0] | stall;
  end

  assign bus.pc_enable_o    = !stall;
  assign bus.if_id_enable_o = !stall;
  assign bus.if_id_flush_o  = bus.redirect_i;
  assign bus.flush_o        = flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush[0] || !bus.id_valid_i) begin
        sel_a_q <= SEL_W'(FWD_RF);
        sel_b_q <= SEL_W'(FWD_RF);
      end else begin
        sel_a_q <= sel_a_nxt;
        sel_b_q <= sel_b_nxt;
      end
      if (stall && (stall_cnt != '1))        stall_cnt <= stall_cnt + 1'b1;
      if (bus.redirect_i && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.fwd_a_sel_o   = sel_a_q;
  assign bus.fwd_b_sel_o   = sel_b_q;
  assign bus.stall_count_o = stall_cnt;
  assign bus.flush_count_o = flush_cnt;

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Directed-vector bench for riscv_hazard_unit: the driver queues expected
// responses, a monitor checks comb outputs mid-cycle and registered ones after the edge.
module tb_riscv_hazard_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_hazard_unit_if #(.REG_ADDR_W(5), .STAGES(3), .CNT_W(4)) bus ();

  riscv_hazard_unit #(
    .REG_ADDR_W(5), .STAGES(3), .LOAD_READY_STAGE(2), .BRANCH_STAGE(1), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, rdir;
    int         pc, ie, ifl, fl;
    int         fa, fb, ev, sc, fc;
  } vec_t;

  vec_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic rdir);
    bus.id_valid_i     = v;
    bus.id_rs1_i       = rs1;
    bus.id_rs2_i       = rs2;
    bus.id_rs1_used_i  = u1;
    bus.id_rs2_used_i  = u2;
    bus.id_rd_i        = rd;
    bus.id_reg_write_i = rw;
    bus.id_mem_read_i  = mr;
    bus.redirect_i     = rdir;
  endtask

  // Inputs, then expected comb outputs, then expected registered outputs after the edge.
  task automatic tv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic u1, input logic u2, input logic [4:0] rd,
                    input logic rw, input logic mr, input logic rdir,
                    input int pc, input int ie, input int ifl, input int fl,
                    input int fa, input int fb, input int ev, input int sc, input int fc);
    vec_t e;
    e.v = v; e.rs1 = rs1; e.rs2 = rs2; e.u1 = u1; e.u2 = u2; e.rd = rd;
    e.rw = rw; e.mr = mr; e.rdir = rdir;
    e.pc = pc; e.ie = ie; e.ifl = ifl; e.fl = fl;
    e.fa = fa; e.fb = fb; e.ev = ev; e.sc = sc; e.fc = fc;
    @(negedge clk);
    drive_in(v, rs1, rs2, u1, u2, rd, rw, mr, rdir);
    q.push_back(e);
  endtask

  initial begin : monitor
    vec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q[0];
        chk("pc_enable",    int'(bus.pc_enable_o),    e.pc);
        chk("if_id_enable", int'(bus.if_id_enable_o), e.ie);
        chk("if_id_flush",  int'(bus.if_id_flush_o),  e.ifl);
        chk("flush",        int'(bus.flush_o),        e.fl);
        @(posedge clk);
        #1;
        chk("fwd_a_sel",   int'(bus.fwd_a_sel_o),   e.fa);
        chk("fwd_b_sel",   int'(bus.fwd_b_sel_o),   e.fb);
        chk("ex_valid",    int'(bus.ex_valid_o),    e.ev);
        chk("stall_count", int'(bus.stall_count_o), e.sc);
        chk("flush_count", int'(bus.flush_count_o), e.fc);
        void'(q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int fc_exp;
    int waited;
    drive_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_pc_enable",    int'(bus.pc_enable_o),    1);
    chk("rst_if_id_enable", int'(bus.if_id_enable_o), 1);
    chk("rst_if_id_flush",  int'(bus.if_id_flush_o),  0);
    chk("rst_flush",        int'(bus.flush_o),        0);
    chk("rst_fwd_a",        int'(bus.fwd_a_sel_o),    0);
    chk("rst_ex_valid",     int'(bus.ex_valid_o),     0);
    chk("rst_stall_count",  int'(bus.stall_count_o),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // add x5,x1,x2 ; add x6,x5,x3 -> EX forward from MEM
    tv(1, 1, 2, 1, 1, 5, 1, 0, 0,   1, 1, 0, 0,   0, 0, 1, 0, 0);
    tv(1, 5, 3, 1, 1, 6, 1, 0, 0,   1, 1, 0, 0,   1, 0, 1, 0, 0);
    // lw x5,0(x1) ; add x6,x5,x5 -> one stall cycle, then forward from WB
    tv(1, 1, 0, 1, 0, 5, 1, 1, 0,   1, 1, 0, 0,   0, 0, 1, 0, 0);
    tv(1, 5, 5, 1, 1, 6, 1, 0, 0,   0, 0, 0, 1,   0, 0, 0, 1, 0);
    tv(1, 5, 5, 1, 1, 6, 1, 0, 0,   1, 1, 0, 0,   2, 2, 1, 1, 0);
    // writer of x0, reader of x0, reader with an unused rs2 that matches
    tv(1, 1, 0, 1, 0, 0, 1, 0, 0,   1, 1, 0, 0,   0, 0, 1, 1, 0);
    tv(1, 0, 0, 1, 1, 7, 1, 0, 0,   1, 1, 0, 0,   0, 0, 1, 1, 0);
    tv(1, 3, 7, 1, 0, 8, 1, 0, 0,   1, 1, 0, 0,   0, 0, 1, 1, 0);
    // redirect while ID reads a forwardable source
    tv(1, 8, 0, 1, 0, 9, 1, 0, 1,   1, 1, 1, 3,   0, 0, 0, 1, 1);
    // load-use coinciding with redirect: redirect wins, no stall counted
    tv(1, 1, 0, 1, 0, 9, 1, 1, 0,   1, 1, 0, 0,   0, 0, 1, 1, 1);
    tv(1, 9, 0, 1, 0,10, 1, 0, 1,   1, 1, 1, 3,   0, 0, 0, 1, 2);
    // non-load forward across a bubble, then youngest-producer priority
    tv(1, 1, 2, 1, 1,11, 1, 0, 0,   1, 1, 0, 0,   0, 0, 1, 1, 2);
    tv(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0,   0, 0, 0, 1, 2);
    tv(1,11,11, 1, 1,11, 1, 0, 0,   1, 1, 0, 0,   2, 2, 1, 1, 2);
    tv(1, 1, 2, 1, 1,11, 1, 0, 0,   1, 1, 0, 0,   0, 0, 1, 1, 2);
    tv(1,11, 0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0,   1, 0, 1, 1, 2);
    // flush counter saturates at 15
    fc_exp = 2;
    for (int i = 0; i < 20; i++) begin
      if (fc_exp < 15) fc_exp++;
      tv(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 3,   0, 0, 0, 1, fc_exp);
    end

    waited = 0;
    while (q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #2;
    chk("queue_drain", q.size(), 0);

    // reset asserted in the middle of a load-use stall
    @(negedge clk);
    drive_in(1, 1, 0, 1, 0, 5, 1, 1, 0);
    @(negedge clk);
    drive_in(1, 5, 5, 1, 1, 6, 1, 0, 0);
    #2;
    chk("pre_rst_pc_enable",  int'(bus.pc_enable_o),   0);
    chk("pre_rst_flush",      int'(bus.flush_o),       1);
    chk("pre_rst_ex_valid",   int'(bus.ex_valid_o),    1);
    chk("pre_rst_flush_count",int'(bus.flush_count_o), 15);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc_enable",    int'(bus.pc_enable_o),    1);
    chk("mid_rst_if_id_enable", int'(bus.if_id_enable_o), 1);
    chk("mid_rst_flush",        int'(bus.flush_o),        0);
    chk("mid_rst_ex_valid",     int'(bus.ex_valid_o),     0);
    chk("mid_rst_fwd_a",        int'(bus.fwd_a_sel_o),    0);
    chk("mid_rst_fwd_b",        int'(bus.fwd_b_sel_o),    0);
    chk("mid_rst_stall_count",  int'(bus.stall_count_o),  0);
    chk("mid_rst_flush_count",  int'(bus.flush_count_o),  0);
    @(negedge clk);
    drive_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_hazard_unit.md
Name: riscv_hazard_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the pipelined RISC-V core.
- Replaces the constant `enable=1` / `bubble=0` ties on the PC and pipeline registers.
- Keeps a scoreboard of in-flight destinations across a configurable number of post-decode stages.
- Generates registered forwarding selects, load-use stalls, redirect flushes, and saturating stall/flush event counters.

Parameters:
- REG_ADDR_W, 5: register-index width.
- STAGES, 3: post-decode stages tracked; index 0=EX, 1=MEM, ..., STAGES-1=WB. Must be >=2.
- LOAD_READY_STAGE, 2: first stage index whose pipeline register carries load data.
- BRANCH_STAGE, 1: stage index where redirect_i is resolved. Range 0..STAGES-2.
- CNT_W, 16: event counter width.
- Localparam SEL_W = $clog2(STAGES).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i, id_rs2_i  in  REG_ADDR_W  source indices in ID.
- id_rs1_used_i, id_rs2_used_i  in  1  source actually read.
- id_rd_i  in  REG_ADDR_W  destination in ID.
- id_reg_write_i  in  1  ID instruction writes rd.
- id_mem_read_i  in  1  ID instruction is a load.
- redirect_i  in  1  taken branch/jump resolved at BRANCH_STAGE this cycle.
- pc_enable_o  out  1  PC register enable.
- if_id_enable_o  out  1  IF/ID register enable.
- if_id_flush_o  out  1  IF/ID loads a bubble.
- flush_o  out  STAGES  bit k=1: register feeding stage k loads a bubble this edge.
- fwd_a_sel_o, fwd_b_sel_o  out  SEL_W  EX operand source; 0=register file, k=stage-k pipeline register. Registered.
- ex_valid_o  out  1  EX scoreboard entry is valid.
- stall_count_o, flush_count_o  out  CNT_W  saturating event counters.

Behaviour:
- Scoreboard: STAGES entries of {valid, rd, reg_write, mem_read}.
  - Every edge, entry k shifts to k+1 and entry STAGES-1 retires.
  - Entry 0 loads the ID instruction, or a bubble (valid=0) when flush_o[0]=1 or id_valid_i=0.
- Register file is write-before-read, so WB-stage producers need no ID bypass.
- Match at entry k (per used source): valid & reg_write & rd!=0 & rd==rs.
- Load-use hazard: a matching entry k with mem_read=1 and k+1 < LOAD_READY_STAGE.
  - Response: pc_enable_o=0, if_id_enable_o=0, flush_o[0]=1, flush_o[others]=0. Combinational, same cycle.
  - With defaults, exactly a one-cycle stall for a load immediately followed by a consumer.
- Redirect (redirect_i=1):
  - if_id_flush_o=1.
  - flush_o[k]=1 for k in 0..BRANCH_STAGE.
  - Scoreboard entries landing at indices 0..BRANCH_STAGE are invalidated.
  - pc_enable_o=1.
- Simultaneous redirect and load-use: the redirect wins. The stall is suppressed, not counted, and the consumer is killed.
- Forwarding selects are computed in ID and registered on the edge the instruction enters EX.
  - Select = k+1 for the youngest (lowest k) matching entry with k+1 <= STAGES-1; otherwise 0.
  - When the instruction is stalled or flushed in, the selects register 0.
  - Selects hold during no-update cycles only when the EX entry is unchanged (never in the current design: EX always advances).
- Counters:
  - stall_count_o increments once per load-use stall cycle.
  - flush_count_o increments once per redirect cycle.
  - Both saturate at all-ones, never wrap.
- Reset (asynchronous, any time, including mid-stall):
  - All entries invalid; fwd selects=0; counters=0; ex_valid_o=0.
  - Combinational outputs settle to pc_enable_o=1, if_id_enable_o=1, if_id_flush_o=0, flush_o=0, provided redirect_i=0.
- Latency: stall/flush outputs have 0 cycles; fwd selects and ex_valid_o have 1 cycle.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - Scoreboard entry struct.
  - Stage index constants (STG_EX, STG_MEM, STG_WB).
  - Forward-select encoding constants (FWD_RF=0).
- One natural sub-module: hazard_scoreboard (shift register plus match vector generation).
- Stall/flush/forward logic and counters stay in the top.

Test Plan:
- add x5,x1,x2 then add x6,x5,x3 (back-to-back) -> second instruction in EX has fwd_a_sel_o=1 (MEM), no stall, stall_count_o=0.
- lw x5,0(x1) then add x6,x5,x5 -> one cycle: pc_enable_o=0, if_id_enable_o=0, flush_o=3'b001, stall_count_o=1. Next cycle fwd_a_sel_o=fwd_b_sel_o=2 (WB).
- Writer to x0 followed by reader of x0, and a reader with rs2_used=0 matching rs2 -> selects 0, no stall.
- redirect_i=1 with BRANCH_STAGE=1 -> if_id_flush_o=1, flush_o=3'b011, flush_count_o=1. ex_valid_o=0 the following cycle.
- Load-use coincident with redirect_i -> pc_enable_o=1, flush_o=3'b011, stall_count_o unchanged.
- Counter saturation with CNT_W=4: 20 redirects -> flush_count_o=15. Assert reset mid-stall -> all registered outputs 0 immediately, stall deasserted.
